// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: FSM states, write-buffer
// entry layout and the byte-store lane helper.
package mips_mem_pkg;

  // Word-address width of the backing RAM as stored in a write-buffer entry.
  localparam int unsigned DMEM_ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RD_REQ  = 2'd2,
    RD_DONE = 2'd3
  } dmem_state_e;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [3:0]             be;
  } wbuf_entry_t;

  // One-hot byte lane for an sb at the given byte offset within the word.
  function automatic logic [3:0] sb_byte_en(input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0001 << offset;
    return be;
  endfunction

endpackage

// File: rtl/dmem_responder_chk.sv
// Protocol checks for the data-memory responder: a load and a store never
// share the M stage, and a posted write holds its bus fields until acked.
module dmem_responder_chk #(
  parameter int unsigned ADDR_W = 30
) (
  input logic              clk,
  input logic              reset,
  input logic              memreadM,
  input logic              memwriteM,
  input logic              mem_req,
  input logic              mem_we,
  input logic              mem_ack,
  input logic [ADDR_W-1:0] mem_addr,
  input logic [31:0]       mem_wdata,
  input logic [3:0]        mem_be
);

  a_no_load_and_store : assert property (
    @(posedge clk) disable iff (!reset) !(memreadM && memwriteM));

  a_write_held_until_ack : assert property (
    @(posedge clk) disable iff (!reset)
    (mem_req && mem_we && !mem_ack) |=>
      (mem_req && mem_we && $stable(mem_addr) && $stable(mem_wdata) && $stable(mem_be)));

endmodule

// File: rtl/dmem_wbuf.sv
// Posted-store FIFO: DEPTH entries, strictly in-order, head presented
// combinationally. Pushes into a full buffer and pops from an empty one
// are ignored.
module dmem_wbuf
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  wbuf_entry_t      push_entry_i,
  input  logic             pop_i,
  output wbuf_entry_t      head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wbuf_entry_t      mem_q [DEPTH];
  wbuf_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push_s = push_i & ~full_o;
    do_pop_s  = pop_i & ~empty_o;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: posts stores into a write buffer, serves loads
// after the buffer drains, and stalls the pipeline while a load is pending
// or a store finds the buffer full.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic              sbM,
  input  logic [31:0]       aluoutM,
  input  logic [31:0]       writedataM,
  output logic [31:0]       readdataM,
  output logic              stallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  dmem_state_e      state_q, state_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [ADDR_W-1:0] word_addr_s;
  wbuf_entry_t       st_entry_s;
  wbuf_entry_t       head_s;
  logic              push_s, pop_s;
  logic              full_s, empty_s;
  logic [CNT_W-1:0]  count_s;
  logic              stall_s;
  logic              mem_req_s, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0]       mem_wdata_s;
  logic [3:0]        mem_be_s;

  assign word_addr_s = aluoutM[ADDR_W+1:2];

  // Store encoder: sw writes the whole word, sb replicates the byte and
  // enables only the addressed lane.
  always_comb begin
    st_entry_s.addr = DMEM_ADDR_W'(word_addr_s);
    if (sbM) begin
      st_entry_s.be   = sb_byte_en(aluoutM[1:0]);
      st_entry_s.data = {4{writedataM[7:0]}};
    end else begin
      st_entry_s.be   = 4'hF;
      st_entry_s.data = writedataM;
    end
  end

  dmem_wbuf #(
    .DEPTH (DEPTH)
  ) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_s),
    .push_entry_i (st_entry_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .count_o      (count_s)
  );

  // FSM next state, stall, buffer push/pop and load data capture.
  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    stall_s    = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        pop_s = ~empty_s & mem_ack;
        if (memreadM) begin
          // A load takes priority over a simultaneous store.
          stall_s = 1'b1;
          if (empty_s) begin
            state_d = RD_REQ;
          end else if ((count_s == CNT_W'(1)) && mem_ack) begin
            // The only buffered store retires this edge; go straight to the read.
            state_d = RD_REQ;
          end else begin
            state_d = DRAIN;
          end
        end else if (memwriteM) begin
          // A pop this cycle does not free a slot for the waiting store.
          if (full_s) begin
            stall_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      DRAIN: begin
        stall_s = 1'b1;
        pop_s   = ~empty_s & mem_ack;
        if (empty_s || ((count_s == CNT_W'(1)) && mem_ack)) begin
          state_d = RD_REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      RD_REQ: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          readdata_d = mem_rdata;
          state_d    = RD_DONE;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DONE: begin
        stall_s = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Backing-RAM bus mux: the load read in RD_REQ, otherwise the buffer head.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = 32'h0000_0000;
    mem_be_s    = 4'h0;
    if (state_q == RD_REQ) begin
      mem_req_s  = 1'b1;
      mem_we_s   = 1'b0;
      mem_addr_s = word_addr_s;
      mem_be_s   = 4'hF;
    end else if (((state_q == IDLE) || (state_q == DRAIN)) && !empty_s) begin
      mem_req_s   = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = ADDR_W'(head_s.addr);
      mem_wdata_s = head_s.data;
      mem_be_s    = head_s.be;
    end else begin
      mem_req_s = 1'b0;
    end
  end

  // FSM state and captured load data; reset abandons any RAM transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      readdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
    end
  end

  // Handshake outputs are forced idle while reset is low, without waiting for a clock.
  assign stallM    = reset & stall_s;
  assign mem_req   = reset & mem_req_s;
  assign mem_we    = reset & mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign mem_be    = mem_be_s;
  assign readdataM = readdata_q;

  dmem_responder_chk #(
    .ADDR_W (ADDR_W)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a program-order memory model predicts the bus
// transactions and load results; a monitor pops and compares them as the
// DUT presents them to a latency-programmable RAM.
module tb_dmem_responder;

  localparam int OP_NOP = 0;
  localparam int OP_SW  = 1;
  localparam int OP_SB  = 2;
  localparam int OP_LW  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM, sbM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        stallM, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(4), .ADDR_W(30)) dut (
    .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
    .sbM(sbM), .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  int          tests = 0;
  int          fails = 0;
  bus_t        bus_q[$];
  logic [31:0] load_q[$];
  logic [31:0] ram   [64];
  logic [31:0] model [64];
  bit          ram_stall = 1'b0;
  bit          ack_once  = 1'b0;
  int          fixed_lat = -1;
  int          lat = 0;
  int          cnt = 0;
  bus_t        mon_e;
  logic [31:0] mon_ld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model in program order plus the expected bus transaction list.
  task automatic expect_store(input logic [31:0] a, input logic [31:0] d, input bit is_sb);
    logic [3:0]  be;
    logic [31:0] wd;
    bus_t        e;
    int          idx;
    if (is_sb) begin
      be = 4'b0001 << a[1:0];
      wd = {4{d[7:0]}};
    end else begin
      be = 4'hF;
      wd = d;
    end
    idx = int'(a[7:2]);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
    end
    e.we = 1'b1; e.addr = a[31:2]; e.wdata = wd; e.be = be;
    bus_q.push_back(e);
  endtask

  task automatic expect_load(input logic [31:0] a);
    bus_t e;
    e.we = 1'b0; e.addr = a[31:2]; e.wdata = 32'h0; e.be = 4'hF;
    bus_q.push_back(e);
    load_q.push_back(model[int'(a[7:2])]);
  endtask

  // Abandoned stores never reach RAM, so the model restarts from the RAM contents.
  task automatic resync();
    bus_q.delete();
    load_q.delete();
    for (int i = 0; i < 64; i++) model[i] = ram[i];
  endtask

  // Present one instruction in M and hold it until the pipeline is released.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    memreadM   = (op == OP_LW);
    memwriteM  = (op == OP_SW) || (op == OP_SB);
    sbM        = (op == OP_SB);
    aluoutM    = a;
    writedataM = d;
    if (op == OP_SW) expect_store(a, d, 1'b0);
    if (op == OP_SB) expect_store(a, d, 1'b1);
    if (op == OP_LW) expect_load(a);
    #1;
    while (stallM === 1'b1 && stalls < 300) begin
      stalls++;
      if (stalls == 8) ram_stall = 1'b0;
      @(negedge clk);
      #1;
    end
    if (stallM !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: stallM=%b after %0d cycles, expected release", stallM, stalls);
    end
    @(posedge clk);
    #1;
    memreadM  = 1'b0;
    memwriteM = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((bus_q.size() != 0 || load_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(bus_q.size() + load_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Backing RAM: acks after a programmable number of request cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (reset !== 1'b1) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (ack_once && mem_req) begin
        mem_ack  = 1'b1;
        ack_once = 1'b0;
      end else if (ram_stall || !mem_req) begin
        mem_ack = 1'b0;
        if (!mem_req) cnt = 0;
      end else if (cnt >= lat) begin
        mem_ack = 1'b1;
        cnt     = 0;
        lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
      if (mem_ack) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) ram[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
          mem_rdata = $urandom;
        end else begin
          mem_rdata = ram[mem_addr[5:0]];
        end
      end
    end
  end

  // Monitor: compares every accepted bus transaction and every completed load.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1) begin
        if (mem_req && mem_ack) begin
          if (bus_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL bus_unexpected: got we=%b addr=%h, expected no transaction", mem_we, mem_addr);
          end else begin
            mon_e = bus_q.pop_front();
            check("bus_we", 32'(mem_we), 32'(mon_e.we));
            check("bus_addr", 32'(mem_addr), 32'(mon_e.addr));
            check("bus_be", 32'(mem_be), 32'(mon_e.be));
            if (mon_e.we) check("bus_wdata", mem_wdata, mon_e.wdata);
          end
        end
        if (memreadM && !stallM) begin
          if (load_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL load_unexpected: got readdataM=%h, expected no load result", readdataM);
          end else begin
            mon_ld = load_q.pop_front();
            check("load_data", readdataM, mon_ld);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int op;
    logic [31:0] a;
    reset = 1'b0; memreadM = 1'b0; memwriteM = 1'b0; sbM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0;
    for (int i = 0; i < 64; i++) begin
      ram[i]   = $urandom;
      model[i] = ram[i];
    end
    #1;
    check("rst_stall", 32'(stallM), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", readdataM, 32'd0);
    @(negedge clk); #3 reset = 1'b1;

    // Three back-to-back posted stores with the RAM stalled.
    ram_stall = 1'b1;
    issue(OP_SW, 32'h10, 32'h1111_0001, st); check("t2_sw0_stalls", 32'(st), 32'd0);
    issue(OP_SW, 32'h14, 32'h2222_0002, st); check("t2_sw1_stalls", 32'(st), 32'd0);
    issue(OP_SW, 32'h18, 32'h3333_0003, st); check("t2_sw2_stalls", 32'(st), 32'd0);
    @(negedge clk); #2;
    check("t2_head_req", 32'(mem_req && mem_we), 32'd1);
    check("t2_head_addr", 32'(mem_addr), 32'h4);
    ram_stall = 1'b0;
    wait_drain();

    // Byte store encoding.
    ram_stall = 1'b1;
    issue(OP_SB, 32'h23, 32'h0000_00A5, st);
    @(negedge clk); #2;
    check("t3_addr", 32'(mem_addr), 32'h8);
    check("t3_be", 32'(mem_be), 32'h8);
    check("t3_wdata", mem_wdata, 32'hA5A5_A5A5);
    ram_stall = 1'b0;
    wait_drain();

    // Full buffer: the fifth store waits, and a pop unstalls it only on the next cycle.
    ram_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(OP_SW, 32'(i * 4), $urandom, st);
      check("t4_fill_stalls", 32'(st), 32'd0);
    end
    @(negedge clk);
    memwriteM = 1'b1; sbM = 1'b0; aluoutM = 32'h10; writedataM = 32'hCAFE_0005;
    expect_store(32'h10, 32'hCAFE_0005, 1'b0);
    #1 check("t4_full_stall", 32'(stallM), 32'd1);
    @(negedge clk); #1 check("t4_full_hold", 32'(stallM), 32'd1);
    #2 ack_once = 1'b1;
    @(negedge clk); #2;
    check("t4_ack_seen", 32'(mem_ack), 32'd1);
    check("t4_pop_cycle_stall", 32'(stallM), 32'd1);
    @(negedge clk); #2 check("t4_unstall", 32'(stallM), 32'd0);
    @(posedge clk); #1 memwriteM = 1'b0;
    ram_stall = 1'b0;
    wait_drain();

    // Two buffered stores then a load with RAM latency 3: W, W, R in order.
    ram_stall = 1'b1;
    issue(OP_SW, 32'h40, 32'hBEEF_0040, st);
    issue(OP_SB, 32'h41, 32'h0000_007E, st);
    fixed_lat = 3; lat = 3; cnt = 0;
    ram_stall = 1'b0;
    issue(OP_LW, 32'h40, 32'h0, st);
    check("t5_min_stalls", 32'(st >= 2), 32'd1);
    check("t5_bus_order_done", 32'(bus_q.size()), 32'd0);
    @(negedge clk); #1;
    check("t5_one_cycle_release", 32'(stallM), 32'd0);
    check("t5_no_reread", 32'(mem_req), 32'd0);

    // Minimum load latency with an empty buffer and an immediate ack.
    fixed_lat = 0; lat = 0; cnt = 0;
    issue(OP_LW, 32'h44, 32'h0, st);
    check("t5_lat_min", 32'(st), 32'd2);
    fixed_lat = -1;
    wait_drain();

    // Reset in RD_REQ abandons the read.
    ram_stall = 1'b1;
    @(negedge clk);
    memreadM = 1'b1; aluoutM = 32'h80;
    @(negedge clk); #1;
    check("t6_rdreq_req", 32'(mem_req && !mem_we), 32'd1);
    check("t6_rdreq_addr", 32'(mem_addr), 32'h20);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_req", 32'(mem_req), 32'd0);
    check("t6_rst_stall", 32'(stallM), 32'd0);
    check("t6_rst_rdata", readdataM, 32'd0);
    memreadM = 1'b0;
    resync();
    @(negedge clk); @(negedge clk); #3 reset = 1'b1;
    ram_stall = 1'b0;
    @(negedge clk); #2 check("t6_idle_after_rst", 32'(mem_req), 32'd0);
    issue(OP_LW, 32'h80, 32'h0, st);
    wait_drain();

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      op = (op < 2) ? OP_NOP : (op < 5) ? OP_SW : (op < 7) ? OP_SB : OP_LW;
      a  = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      if (op == OP_LW) a[1:0] = 2'b00;
      if (op == OP_LW) ram_stall = 1'b0;
      else if ($urandom_range(0, 7) == 0) ram_stall = 1'b1;
      issue(op, a, $urandom, st);
    end
    ram_stall = 1'b0;
    wait_drain();

    // Reset mid-run with stores still posted: they are dropped.
    ram_stall = 1'b1;
    issue(OP_SW, 32'h0C, 32'hDEAD_000C, st);
    issue(OP_SW, 32'h2C, 32'hDEAD_002C, st);
    @(negedge clk); #3 reset = 1'b0;
    #1;
    check("t1_rst_stall", 32'(stallM), 32'd0);
    check("t1_rst_req", 32'(mem_req), 32'd0);
    check("t1_rst_rdata", readdataM, 32'd0);
    resync();
    @(negedge clk); @(negedge clk);
    ram_stall = 1'b0;
    #3 reset = 1'b1;
    @(negedge clk); #2 check("t1_count_zero", 32'(mem_req), 32'd0);
    issue(OP_LW, 32'h0C, 32'h0, st);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
